uart_tx_core: RTL and testbench

UART transmitter that serialises one parallel word per valid/ready handshake into an asynchronous frame: start bit, DATA_BITS LSB-first, optional parity, then STOP_BITS stop bits.
Contains its own 1x bit-period divider derived from CLK_FREQ/BAUD_RATE.
Transmit-side counterpart of the 16x-oversampling receive path; sits between a host/FIFO and the serial tx pin.

---
 rtl/uart_tx_core_pkg.sv | 25 ++
 rtl/uart_tx_core_baud.sv | 34 +++
 rtl/uart_tx_core.sv | 145 ++++++++++++++
 tb/tb_uart_tx_core.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_core_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   - FSM state encodings (IDLE, START, DATA, PARITY, STOP)
//   - bit_cyc(): clock cycles per bit for a given clock and line rate
//   - legal ranges for the DATA_BITS and STOP_BITS parameters
package uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    // Integer division: any fractional remainder shows up as baud error.
    function automatic int bit_cyc(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_core_baud.sv
// baud_rate_gen_tx: 1x bit-period tick generator for the UART transmitter.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   restart     - forces the counter to 0 (frame start)
//   enable      - count while high
//   bit_tick    - high in the last cycle of every bit period
module baud_rate_gen_tx #(
    parameter int BIT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic bit_tick
);

    localparam int CW = $clog2(BIT_CYC);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (restart) begin
            cnt_reg <= '0;
        end else if (enable) begin
            cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
        end
    end

    assign bit_tick = enable && (cnt_reg == LAST);

endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter. Accepts one word per valid/ready handshake
// and sends start bit, DATA_BITS data bits LSB first, optional parity bit and
// STOP_BITS stop bits on the registered tx line.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   tx_data    - word to send, latched on handshake
//   tx_valid   - host offers tx_data
//   tx_ready   - core idle, will accept a word
//   tx         - serial line, idles high
//   tx_busy    - frame in progress
//   tx_done    - one-cycle pulse at the end of the final stop bit
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BIT_CYC = bit_cyc(CLK_FREQ, BAUD_RATE);
    localparam logic [3:0] LAST_IDX  = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    if (BIT_CYC < 2) begin : g_bad_bit_cyc
        $error("uart_tx_core: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop
        $error("uart_tx_core: STOP_BITS must be 1 or 2");
    end
    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data
        $error("uart_tx_core: DATA_BITS must be in 5..9");
    end

    uart_state_t          state_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_reg;
    logic [3:0]           idx_reg;
    logic                 stop_idx_reg;
    logic                 tx_reg;
    logic                 done_reg;
    logic                 bit_tick;
    logic                 handshake;

    assign tx_ready  = (state_reg == ST_IDLE);
    assign tx_busy   = !tx_ready;
    assign handshake = tx_valid && tx_ready;
    assign tx        = tx_reg;
    assign tx_done   = done_reg;

    baud_rate_gen_tx #(
        .BIT_CYC (BIT_CYC)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (handshake),
        .enable   (tx_busy),
        .bit_tick (bit_tick)
    );

    // tx is loaded one bit ahead: each tick transition writes the value of
    // the bit that starts on that same edge, so the line is fully registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            idx_reg      <= '0;
            stop_idx_reg <= 1'b0;
            tx_reg       <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    tx_reg <= 1'b1;
                    if (tx_valid) begin
                        shift_reg  <= tx_data;
                        parity_reg <= (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
                        tx_reg     <= 1'b0;
                        state_reg  <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        tx_reg    <= shift_reg[0];
                        idx_reg   <= '0;
                        state_reg <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (idx_reg == LAST_IDX) begin
                            if (PARITY_EN != 0) begin
                                tx_reg    <= parity_reg;
                                state_reg <= ST_PARITY;
                            end else begin
                                tx_reg       <= 1'b1;
                                stop_idx_reg <= 1'b0;
                                state_reg    <= ST_STOP;
                            end
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            tx_reg    <= shift_reg[1];
                            idx_reg   <= idx_reg + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        tx_reg       <= 1'b1;
                        stop_idx_reg <= 1'b0;
                        state_reg    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        if (stop_idx_reg == LAST_STOP) begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            stop_idx_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Testbench for uart_tx_core. Four instances share clk, rst_n, tx_data and
// tx_valid, each at BIT_CYC = 10:
//   dut0: 8N1   dut1: 8E1   dut2: 8O1   dut3: 8N2
module tb_uart_tx_core;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [3:0] ready_w;
    logic [3:0] tx_w;
    logic [3:0] busy_w;
    logic [3:0] done_w;

    int total  = 0;
    int passed = 0;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        uart_tx_core #(
            .CLK_FREQ   (1_000_000),
            .BAUD_RATE  (100_000),
            .DATA_BITS  (8),
            .PARITY_EN  ((gi == 1 || gi == 2) ? 1 : 0),
            .PARITY_ODD ((gi == 2) ? 1 : 0),
            .STOP_BITS  ((gi == 3) ? 2 : 1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .tx_data  (tx_data),
            .tx_valid (tx_valid),
            .tx_ready (ready_w[gi]),
            .tx       (tx_w[gi]),
            .tx_busy  (busy_w[gi]),
            .tx_done  (done_w[gi])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Vector: data word, hand-computed even/odd parity bits, and whether to
    // poke tx_valid with the inverted word in the middle of the frame.
    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       po;
        bit         poke;
    } vec_t;

    vec_t vecs [4];

    function automatic int cfg_par(input int i);
        return (i == 1 || i == 2) ? 1 : 0;
    endfunction

    function automatic int cfg_stop(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int i);
        return (1 + 8 + cfg_par(i) + cfg_stop(i)) * 10;
    endfunction

    // Expected line level k cycles after the handshake edge.
    function automatic logic exp_tx(input int i, input vec_t v, input int k);
        int b;
        b = k / 10;
        if (b == 0) return 1'b0;
        if (b <= 8) return v.data[b-1];
        if (cfg_par(i) == 1 && b == 9) return (i == 2) ? v.po : v.pe;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s dut%0d: got %0d, expected %0d", name, idx, act, exp);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(&ready_w) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 0, int'(&ready_w), 1);
    endtask

    task automatic run_frame(input vec_t v);
        int first_bad [4];
        int done_k    [4];
        int done_n    [4];
        int busy_n    [4];
        for (int i = 0; i < 4; i++) begin
            first_bad[i] = -1; done_k[i] = -1; done_n[i] = 0; busy_n[i] = 0;
        end
        wait_idle();
        tx_data  = v.data;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        for (int k = 0; k < 130; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (tx_w[i] !== exp_tx(i, v, k) && first_bad[i] < 0) first_bad[i] = k;
                if (done_w[i]) begin
                    done_n[i]++;
                    if (done_k[i] < 0) done_k[i] = k;
                end
                if (busy_w[i]) busy_n[i]++;
            end
            if (v.poke && k == 30) begin tx_data = ~v.data; tx_valid = 1'b1; end
            if (v.poke && k == 31) begin tx_data = v.data;  tx_valid = 1'b0; end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) begin
            chk("frame_first_bad_cycle", i, first_bad[i], -1);
            chk("done_cycle", i, done_k[i], frame_len(i));
            chk("done_pulses", i, done_n[i], 1);
            chk("busy_cycles", i, busy_n[i], frame_len(i));
        end
        $display("frame data=%02h poke=%0d done@ %0d/%0d/%0d/%0d", v.data, v.poke,
                 done_k[0], done_k[1], done_k[2], done_k[3]);
    endtask

    initial begin
        int done_t [2];
        int done_c;
        int tx100;
        int tx101;
        int lows_start;
        int lows_ones;

        vecs[0] = '{data: 8'hA5, pe: 1'b0, po: 1'b1, poke: 1'b1};
        vecs[1] = '{data: 8'h07, pe: 1'b1, po: 1'b0, poke: 1'b0};
        vecs[2] = '{data: 8'hFF, pe: 1'b0, po: 1'b1, poke: 1'b0};
        vecs[3] = '{data: 8'h3C, pe: 1'b0, po: 1'b1, poke: 1'b0};

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_tx", i, int'(tx_w[i]), 1);
            chk("reset_ready", i, int'(ready_w[i]), 1);
            chk("reset_busy", i, int'(busy_w[i]), 0);
            chk("reset_done", i, int'(done_w[i]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int n = 0; n < 4; n++) run_frame(vecs[n]);

        // Back-to-back on dut0: 0x00 then 0xFF with tx_valid held high.
        wait_idle();
        done_t[0] = -1; done_t[1] = -1; done_c = 0;
        tx100 = -1; tx101 = -1; lows_start = 0; lows_ones = 0;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_data = 8'hFF;
        for (int k = 0; k < 210; k++) begin
            if (done_w[0]) begin
                if (done_c < 2) done_t[done_c] = k;
                done_c++;
            end
            if (k == 100) tx100 = int'(tx_w[0]);
            if (k == 101) begin
                tx101 = int'(tx_w[0]);
                tx_valid = 1'b0;
            end
            if (k >= 101 && k <= 110 && !tx_w[0]) lows_start++;
            if (k >= 111 && k <= 200 && !tx_w[0]) lows_ones++;
            @(posedge clk); #1;
        end
        chk("b2b_done1_cycle", 0, done_t[0], 100);
        chk("b2b_done2_cycle", 0, done_t[1], 201);
        chk("b2b_done_pulses", 0, done_c, 2);
        chk("b2b_tx_at_done", 0, tx100, 1);
        chk("b2b_second_start", 0, tx101, 0);
        chk("b2b_start_low_cycles", 0, lows_start, 10);
        chk("b2b_ff_low_cycles", 0, lows_ones, 0);
        $display("back-to-back 00,FF done@ %0d,%0d", done_t[0], done_t[1]);

        // Reset in the middle of data bit 3 of 0x55.
        wait_idle();
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (45) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_bit3", 0, int'(tx_w[0]), 0);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("async_reset_tx", i, int'(tx_w[i]), 1);
            chk("async_reset_ready", i, int'(ready_w[i]), 1);
            chk("async_reset_busy", i, int'(busy_w[i]), 0);
        end
        done_c = 0;
        repeat (3) begin
            @(posedge clk); #1;
            done_c += $countones(done_w);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) begin
            @(posedge clk); #1;
            done_c += $countones(done_w);
        end
        chk("no_done_after_reset", 0, done_c, 0);
        $display("reset mid-frame 55: done pulses seen %0d", done_c);

        run_frame(vecs[3]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
